// File: rtl/expand_key_iterative_pkg.sv
// Shared AES key-schedule definitions: word/round-key types, Nk/Nr derivation,
// Rcon start value with its xtime update, FSM state type and the forward S-box.
package AESDefinitions;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] roundKey_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_DRAIN
  } expand_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic int unsigned nk_of(input int unsigned key_bits);
    return key_bits / 32;
  endfunction

  function automatic int unsigned nr_of(input int unsigned key_bits);
    return nk_of(key_bits) + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/expand_key_iterative_sub_word.sv
// SubWord: four parallel forward S-box lookups on one schedule word.
module sub_word
  import AESDefinitions::*;
(
  input  word_t word_i,
  output word_t word_o
);

  assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                   SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/expand_key_iterative.sv
// Iterative AES key schedule: one 32-bit word per cycle, round keys streamed out
// over valid/ready. Define EXPAND_KEY_STORE_EN to add a readable round-key store.
module expand_key_iterative
  import AESDefinitions::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                validInput,
  input  logic [KEY_BITS-1:0] key,
  output logic                ready,
  output logic [127:0]        roundKey,
  output logic [3:0]          roundIndex,
  output logic                roundKeyValid,
  input  logic                roundKeyReady,
`ifdef EXPAND_KEY_STORE_EN
  input  logic [3:0]          rdIndex,
  output logic [127:0]        rdKey,
  output logic                storeValid,
`endif
  output logic                busy,
  output logic                done
);

  localparam int unsigned NK        = nk_of(KEY_BITS);
  localparam int unsigned NR        = nr_of(KEY_BITS);
  localparam int unsigned LAST_WORD = 4 * (NR + 1) - 1;

  expand_state_t state_q;
  word_t         window_q [NK];
  word_t         buf_q    [4];
  logic [2:0]    bufCnt_q;
  logic [5:0]    wordIdx_q;
  logic [2:0]    modIdx_q;
  logic [7:0]    rcon_q;
  logic          ready_q, busy_q, done_q, valid_q;
  roundKey_t     roundKey_q;
  logic [3:0]    roundIndex_q;

  logic [255:0]  keyPad;
  word_t         lastWord, swIn, swOut, temp, newWord;
  roundKey_t     presentKey;
  logic          presentNow, stall;

  always_comb begin
    keyPad     = 256'(key) << (256 - KEY_BITS);
    lastWord   = window_q[NK-1];
    swIn       = (modIdx_q == 3'd0) ? {lastWord[23:0], lastWord[31:24]} : lastWord;
    temp       = lastWord;
    if (modIdx_q == 3'd0) begin
      temp = swOut ^ {rcon_q, 24'h0};
    end else if (NK == 8 && modIdx_q == 3'd4) begin
      temp = swOut;
    end
    newWord    = window_q[0] ^ temp;
    // A full buffer only occurs for 256-bit keys, where words 4..7 arrive at load
    // while round key 0 still occupies the output; it drains ahead of the new word.
    presentNow = (bufCnt_q >= 3'd3);
    presentKey = (bufCnt_q == 3'd4) ? {buf_q[0], buf_q[1], buf_q[2], buf_q[3]}
                                    : {buf_q[0], buf_q[1], buf_q[2], newWord};
    stall      = valid_q & ~roundKeyReady;
  end

  sub_word u_sub_word (
    .word_i (swIn),
    .word_o (swOut)
  );

`ifdef EXPAND_KEY_STORE_EN
  roundKey_t store_q [NR+1];
  logic      storeValid_q;

  assign rdKey      = (rdIndex <= 4'(NR)) ? store_q[rdIndex] : '0;
  assign storeValid = storeValid_q;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      for (int unsigned i = 0; i < NK; i++) window_q[i] <= '0;
      for (int unsigned i = 0; i < 4; i++) buf_q[i] <= '0;
      bufCnt_q     <= '0;
      wordIdx_q    <= '0;
      modIdx_q     <= '0;
      rcon_q       <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      roundKey_q   <= '0;
      roundIndex_q <= '0;
`ifdef EXPAND_KEY_STORE_EN
      for (int unsigned i = 0; i <= NR; i++) store_q[i] <= '0;
      storeValid_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (validInput) begin
            for (int unsigned i = 0; i < NK; i++) window_q[i] <= keyPad[255-32*i -: 32];
            for (int unsigned i = 0; i < 4; i++) buf_q[i] <= keyPad[127-32*i -: 32];
            bufCnt_q     <= 3'(NK - 4);
            wordIdx_q    <= 6'(NK);
            modIdx_q     <= '0;
            rcon_q       <= RCON_INIT;
            roundKey_q   <= keyPad[255 -: 128];
            roundIndex_q <= '0;
            valid_q      <= 1'b1;
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_GEN;
`ifdef EXPAND_KEY_STORE_EN
            store_q[0]   <= keyPad[255 -: 128];
            storeValid_q <= 1'b0;
`endif
          end
        end
        S_GEN: begin
          if (!stall) begin
            for (int unsigned i = 0; i + 1 < NK; i++) window_q[i] <= window_q[i+1];
            window_q[NK-1] <= newWord;
            wordIdx_q      <= wordIdx_q + 6'd1;
            modIdx_q       <= (modIdx_q == 3'(NK - 1)) ? 3'd0 : modIdx_q + 3'd1;
            if (modIdx_q == 3'd0) rcon_q <= xtime(rcon_q);
            valid_q <= 1'b0;
            if (presentNow) begin
              roundKey_q   <= presentKey;
              roundIndex_q <= roundIndex_q + 4'd1;
              valid_q      <= 1'b1;
`ifdef EXPAND_KEY_STORE_EN
              store_q[roundIndex_q + 4'd1] <= presentKey;
`endif
            end
            if (bufCnt_q == 3'd4) begin
              buf_q[0] <= newWord;
              bufCnt_q <= 3'd1;
            end else if (bufCnt_q == 3'd3) begin
              bufCnt_q <= 3'd0;
            end else begin
              buf_q[bufCnt_q[1:0]] <= newWord;
              bufCnt_q             <= bufCnt_q + 3'd1;
            end
            if (wordIdx_q == 6'(LAST_WORD)) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (valid_q && roundKeyReady) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`ifdef EXPAND_KEY_STORE_EN
            storeValid_q <= 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready         = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign roundKeyValid = valid_q;
  assign roundKey      = roundKey_q;
  assign roundIndex    = roundIndex_q;

endmodule

// File: tb/tb_expand_key_iterative.sv
// Directed bench for expand_key_iterative: FIPS-197 vectors for all key sizes,
// backpressure, ignored validInput, mid-expansion reset; store checks under EXPAND_KEY_STORE_EN.
module tb_expand_key_iterative;

  localparam logic [127:0] K128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  localparam logic [127:0] R128 [11] = '{
    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
    128'ha0fafe17_88542cb1_23a33939_2a6c7605,
    128'hf2c295f2_7a96b943_5935807a_7359f67f,
    128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
    128'hef44a541_a8525b7f_b671253b_db0bad00,
    128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
    128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
    128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
    128'head27321_b58dbad2_312bf560_7f8d292f,
    128'hac7766f3_19fadc21_28d12941_575c006e,
    128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
  };
  localparam logic [127:0] R192_12 = 128'he98ba06f_448c773c_8ecc7204_01002202;
  localparam logic [127:0] R256_14 = 128'hfe4890d1_e6188d0b_046df344_706c631e;

  logic clock = 1'b0;
  logic resetN;
  always #5 clock = ~clock;

  logic         vi128, rdy128, rkv128, rkr128, busy128, done128;
  logic [127:0] key128, rk128;
  logic [3:0]   ri128;
  logic         vi192, rdy192, rkv192, rkr192, busy192, done192;
  logic [191:0] key192;
  logic [127:0] rk192;
  logic [3:0]   ri192;
  logic         vi256, rdy256, rkv256, rkr256, busy256, done256;
  logic [255:0] key256;
  logic [127:0] rk256;
  logic [3:0]   ri256;
`ifdef EXPAND_KEY_STORE_EN
  logic [3:0]   rdIdx128, rdIdx192, rdIdx256;
  logic [127:0] rdKey128, rdKey192, rdKey256;
  logic         sv128, sv192, sv256;
`endif

  int checks = 0;
  int errors = 0;

  expand_key_iterative #(.KEY_BITS(128)) dut128 (
    .clock(clock), .resetN(resetN), .validInput(vi128), .key(key128), .ready(rdy128),
    .roundKey(rk128), .roundIndex(ri128), .roundKeyValid(rkv128), .roundKeyReady(rkr128),
`ifdef EXPAND_KEY_STORE_EN
    .rdIndex(rdIdx128), .rdKey(rdKey128), .storeValid(sv128),
`endif
    .busy(busy128), .done(done128)
  );

  expand_key_iterative #(.KEY_BITS(192)) dut192 (
    .clock(clock), .resetN(resetN), .validInput(vi192), .key(key192), .ready(rdy192),
    .roundKey(rk192), .roundIndex(ri192), .roundKeyValid(rkv192), .roundKeyReady(rkr192),
`ifdef EXPAND_KEY_STORE_EN
    .rdIndex(rdIdx192), .rdKey(rdKey192), .storeValid(sv192),
`endif
    .busy(busy192), .done(done192)
  );

  expand_key_iterative #(.KEY_BITS(256)) dut256 (
    .clock(clock), .resetN(resetN), .validInput(vi256), .key(key256), .ready(rdy256),
    .roundKey(rk256), .roundIndex(ri256), .roundKeyValid(rkv256), .roundKeyReady(rkr256),
`ifdef EXPAND_KEY_STORE_EN
    .rdIndex(rdIdx256), .rdKey(rdKey256), .storeValid(sv256),
`endif
    .busy(busy256), .done(done256)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs the AES-128 stream from just after the accept edge until done (bounded).
  task automatic stream128(input bit randomReady, input bit glitch,
                           output int lastCycle, output int stalls,
                           output int acceptEdge, output int doneCycle);
    int           cyc = 0;
    int           expIdx = 0;
    bit           held = 1'b0;
    logic [127:0] heldKey = '0;
    lastCycle = -1; stalls = 0; acceptEdge = -1; doneCycle = -1;
    while (cyc < 300 && doneCycle < 0) begin
      if (held) chk("stall_hold", rk128, heldKey);
      if (rkv128 && ri128 == 4'd10 && lastCycle < 0) lastCycle = cyc;
      if (glitch && cyc == 5) begin
        chk("ready_in_gen", 128'(rdy128), 128'(1'b0));
        vi128  = 1'b1;
        key128 = ~K128;
      end else begin
        vi128 = 1'b0;
      end
      rkr128 = randomReady ? ($urandom_range(0, 2) != 0) : 1'b1;
      held   = rkv128 && !rkr128;
      heldKey = rk128;
      if (held && lastCycle < 0) stalls++;
      if (rkv128 && rkr128) begin
        chk($sformatf("idx_r%0d", expIdx), 128'(ri128), 128'(expIdx));
        chk($sformatf("key_r%0d", expIdx), rk128, R128[expIdx % 11]);
        if (expIdx == 10) acceptEdge = cyc + 1;
        expIdx++;
      end
      @(posedge clock); #1;
      cyc++;
      if (done128) doneCycle = cyc;
    end
    rkr128 = 1'b1;
    chk("round_key_count", 128'(expIdx), 128'(11));
  endtask

  task automatic accept128();
    key128 = K128;
    vi128  = 1'b1;
    @(posedge clock); #1;
    vi128  = 1'b0;
  endtask

  initial begin
    int last, stalls, acc, dn, c1, cl;
    logic [127:0] r1, rl;
    resetN = 1'b0;
    vi128 = 1'b0; vi192 = 1'b0; vi256 = 1'b0;
    rkr128 = 1'b1; rkr192 = 1'b1; rkr256 = 1'b1;
    key128 = '0; key192 = '0; key256 = '0;
`ifdef EXPAND_KEY_STORE_EN
    rdIdx128 = '0; rdIdx192 = '0; rdIdx256 = '0;
`endif
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 128'(rdy128), 128'(1'b1));
    chk("rst_valid", 128'(rkv128), 128'(1'b0));
    chk("rst_index", 128'(ri128), 128'(0));
    chk("rst_key", rk128, 128'(0));
    chk("rst_busy_done", 128'({busy128, done128}), 128'(0));
    resetN = 1'b1;
    @(posedge clock); #1;

    // AES-128, ready held high, with a foreign key offered mid-expansion
    accept128();
    chk("r0_valid", 128'(rkv128), 128'(1'b1));
    chk("r0_busy_ready", 128'({busy128, rdy128}), 128'(2'b10));
    stream128(1'b0, 1'b1, last, stalls, acc, dn);
    chk("r10_cycle", 128'(last), 128'(40));
    chk("done_cycle", 128'(dn), 128'(41));
    chk("done_ready_busy", 128'({done128, rdy128, busy128}), 128'(3'b110));
    @(posedge clock); #1;
    chk("done_pulse_end", 128'(done128), 128'(1'b0));
`ifdef EXPAND_KEY_STORE_EN
    rdIdx128 = 4'd10;
    #1;
    chk("store_r10", rdKey128, R128[10]);
    chk("store_valid_set", 128'(sv128), 128'(1'b1));
`endif

    // AES-128 with random backpressure
    accept128();
`ifdef EXPAND_KEY_STORE_EN
    chk("store_valid_clr", 128'(sv128), 128'(1'b0));
`endif
    stream128(1'b1, 1'b0, last, stalls, acc, dn);
    chk("bp_r10_cycle", 128'(last), 128'(40 + stalls));
    chk("bp_done_cycle", 128'(dn), 128'(acc));

    // AES-192
    key192 = K192; vi192 = 1'b1;
    @(posedge clock); #1;
    vi192 = 1'b0;
    chk("k192_r0", rk192, K192[191 -: 128]);
    c1 = -1; cl = -1; r1 = '0; rl = '0;
    for (int c = 1; c <= 80 && !done192; c++) begin
      @(posedge clock); #1;
      if (rkv192 && ri192 == 4'd1 && c1 < 0) begin c1 = c; r1 = rk192; end
      if (rkv192 && ri192 == 4'd12 && cl < 0) begin cl = c; rl = rk192; end
    end
    chk("k192_r1_cycle", 128'(c1), 128'(2));
    chk("k192_r1_hi", 128'(r1[127:64]), 128'(64'h62f8ead2_522c6b7b));
    chk("k192_r12_cycle", 128'(cl), 128'(46));
    chk("k192_r12", rl, R192_12);
    chk("k192_done", 128'(done192), 128'(1'b1));

    // AES-256
    key256 = K256; vi256 = 1'b1;
    @(posedge clock); #1;
    vi256 = 1'b0;
    chk("k256_r0", rk256, K256[255 -: 128]);
    c1 = -1; cl = -1; r1 = '0; rl = '0;
    for (int c = 1; c <= 80 && !done256; c++) begin
      @(posedge clock); #1;
      if (rkv256 && ri256 == 4'd1 && c1 < 0) begin c1 = c; r1 = rk256; end
      if (rkv256 && ri256 == 4'd14 && cl < 0) begin cl = c; rl = rk256; end
    end
    chk("k256_r1", r1, K256[127:0]);
    chk("k256_r14_cycle", 128'(cl), 128'(52));
    chk("k256_r14", rl, R256_14);
    chk("k256_done", 128'(done256), 128'(1'b1));

    // Reset in the middle of an AES-128 expansion, then a clean restart
    accept128();
    for (int c = 0; c < 40 && !(rkv128 && ri128 == 4'd5); c++) begin
      @(posedge clock); #1;
    end
    chk("pre_reset_r5", 128'({rkv128, ri128}), 128'({1'b1, 4'd5}));
    resetN = 1'b0;
    #1;
    chk("mid_rst_outputs", 128'({rdy128, rkv128, ri128, busy128, done128}), 128'(8'b1000_0000));
    chk("mid_rst_key", rk128, 128'(0));
    #3;
    resetN = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_idle", 128'({rdy128, busy128, done128}), 128'(3'b100));
    accept128();
    chk("restart_r0", rk128, R128[0]);
    stream128(1'b0, 1'b0, last, stalls, acc, dn);
    chk("restart_r10_cycle", 128'(last), 128'(40));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
